// File: rtl/sr_imem_loader_if.sv
// rtl/sr_imem_loader_if.sv - byte-stream, instruction-memory write and CPU control bundle for sr_imem_loader
//
// Signals:
//   byte_valid/byte_data/byte_ready : upstream byte stream handshake
//   reload                          : single-cycle pulse to restart image loading
//   im_we/im_waddr/im_wdata         : instruction memory write port (word addressed)
//   cpu_rst_n/done/err              : CPU reset and load status
// Modports:
//   master : upstream/system side (drives bytes and reload, observes results)
//   slave  : the loader itself
interface sr_imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              reload;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              err;

    modport master (
        output byte_valid,
        output byte_data,
        output reload,
        input  byte_ready,
        input  im_we,
        input  im_waddr,
        input  im_wdata,
        input  cpu_rst_n,
        input  done,
        input  err
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  reload,
        output byte_ready,
        output im_we,
        output im_waddr,
        output im_wdata,
        output cpu_rst_n,
        output done,
        output err
    );
endinterface

// File: rtl/sr_imem_loader.sv
// rtl/sr_imem_loader.sv - boot-time program loader feeding the CPU instruction memory
//
// Receives a framed byte image (LEN_LO, LEN_HI, N*4 payload bytes, XOR checksum),
// writes the payload as little-endian 32-bit words to instruction memory at word
// addresses 0..N-1, and releases the CPU from reset only after the checksum matches.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : sr_imem_loader_if.slave
//            byte_valid/byte_data/byte_ready - upstream byte handshake
//            reload                          - restart loading (priority over a byte accept)
//            im_we/im_waddr/im_wdata         - instruction memory write port
//            cpu_rst_n/done/err              - CPU reset and load status
module sr_imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_imem_loader_if.slave    bus
);

    localparam logic [16:0] DEPTH_C = 17'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   widx_q;      // one extra bit so N == DEPTH compares cleanly
    logic [1:0]        bcnt_q;
    logic [23:0]       word_q;      // first three bytes of the word being assembled
    logic [7:0]        xor_q;

    logic              byte_ready_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_waddr_q;
    logic [31:0]       im_wdata_q;
    logic              cpu_rst_n_q;
    logic              done_q;
    logic              err_q;

    logic              accept_d;
    logic [16:0]       len_n_d;
    logic [ADDR_W:0]   widx_inc_d;

    // byte_ready is a pure register, so accept never loops back through byte_valid
    assign accept_d   = bus.byte_valid && byte_ready_q;
    assign len_n_d    = {1'b0, bus.byte_data, len_lo_q};
    assign widx_inc_d = widx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LEN_LO;
            len_lo_q     <= 8'h00;
            len_q        <= 16'h0000;
            widx_q       <= '0;
            bcnt_q       <= 2'd0;
            word_q       <= 24'h000000;
            xor_q        <= 8'h00;
            byte_ready_q <= 1'b1;
            im_we_q      <= 1'b0;
            im_waddr_q   <= '0;
            im_wdata_q   <= 32'h0000_0000;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (bus.reload) begin
            // Any byte offered in this cycle is dropped; memory contents are left alone.
            state_q      <= S_LEN_LO;
            widx_q       <= '0;
            bcnt_q       <= 2'd0;
            xor_q        <= 8'h00;
            byte_ready_q <= 1'b1;
            im_we_q      <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            case (state_q)
                S_LEN_LO: begin
                    if (accept_d) begin
                        len_lo_q <= bus.byte_data;
                        state_q  <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (accept_d) begin
                        len_q <= len_n_d[15:0];
                        if (len_n_d > DEPTH_C) begin
                            state_q      <= S_ERR;
                            byte_ready_q <= 1'b0;
                            err_q        <= 1'b1;
                        end else if (len_n_d == 17'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (im_we_q) begin
                        // Write cycle: ready was held low, so no byte can arrive here.
                        widx_q       <= widx_inc_d;
                        byte_ready_q <= 1'b1;
                        if (16'(widx_inc_d) == len_q) begin
                            state_q <= S_CSUM;
                        end
                    end else if (accept_d) begin
                        xor_q  <= xor_q ^ bus.byte_data;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            im_we_q      <= 1'b1;
                            im_waddr_q   <= widx_q[ADDR_W-1:0];
                            im_wdata_q   <= {bus.byte_data, word_q};
                            byte_ready_q <= 1'b0;
                        end else begin
                            word_q <= {bus.byte_data, word_q[23:8]};
                        end
                    end
                end

                S_CSUM: begin
                    if (accept_d) begin
                        byte_ready_q <= 1'b0;
                        if (bus.byte_data == xor_q) begin
                            state_q     <= S_RUN;
                            cpu_rst_n_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                end

                S_ERR: begin
                end

                default: begin
                    state_q      <= S_LEN_LO;
                    byte_ready_q <= 1'b1;
                    cpu_rst_n_q  <= 1'b0;
                    done_q       <= 1'b0;
                    err_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.im_we      = im_we_q;
    assign bus.im_waddr   = im_waddr_q;
    assign bus.im_wdata   = im_wdata_q;
    assign bus.cpu_rst_n  = cpu_rst_n_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_sr_imem_loader.sv
// tb/tb_sr_imem_loader.sv - self-checking bench for sr_imem_loader
module tb_sr_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    sr_imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    typedef struct {
        logic [87:0] frame;   // bytes in send order, first byte in the top bits
        int          nb;
        logic        e_done;
        logic        e_err;
        int          e_wr;
        int          gap;
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    wr_t   exp_q[$];
    int    wr_cnt = 0;
    logic [31:0] mem [0:DEPTH-1];
    int    max_addr = -1;
    int    wlog [0:10];

    // Reference frame parser
    int          m_pos, m_n, m_widx, m_bc;
    logic [7:0]  m_lo, m_xor;
    logic [31:0] m_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_n = 0; m_widx = 0; m_bc = 0; m_lo = 8'h00; m_xor = 8'h00; m_word = 32'h0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pos == 0) m_lo = b;
        else if (m_pos == 1) m_n = int'({b, m_lo});
        else if (m_n <= DEPTH && m_widx < m_n) begin
            m_xor  = m_xor ^ b;
            m_word = {b, m_word[31:8]};
            m_bc++;
            if (m_bc == 4) begin
                exp_q.push_back('{a: ADDR_W'(m_widx), d: m_word});
                m_widx++;
                m_bc = 0;
            end
        end
        m_pos++;
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.im_we) begin
            wr_t e;
            wr_cnt++;
            mem[bus.im_waddr] = bus.im_wdata;
            if (int'(bus.im_waddr) > max_addr) max_addr = int'(bus.im_waddr);
            check("ready_low_in_we", {31'b0, bus.byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h with no expected write", bus.im_waddr, bus.im_wdata);
            end else begin
                e = exp_q.pop_front();
                check("waddr", 32'(bus.im_waddr), 32'(e.a));
                check("wdata", bus.im_wdata, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
        int g = 0;
        if (gap > 0) begin
            while (g < 4 && $urandom_range(99) < gap) begin
                @(negedge clk);
                g++;
            end
        end
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        waited = 0;
        while (!bus.byte_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: byte %h not accepted within 20 cycles", b);
        end else begin
            @(posedge clk);
            model_byte(b);
        end
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
        model_reset();
    endtask

    task automatic run_vec(input vec_t v);
        int w0, w;
        pulse_reload();
        check("reload_ready", {31'b0, bus.byte_ready}, 32'd1);
        check("reload_done", {31'b0, bus.done}, 32'd0);
        check("reload_cpu_rst_n", {31'b0, bus.cpu_rst_n}, 32'd0);
        w0 = wr_cnt;
        for (int i = 0; i < v.nb; i++) begin
            send_byte(v.frame[87 - 8*i -: 8], v.gap, w);
            wlog[i] = w;
        end
        // One cycle after the final accept
        check("done_next_cycle", {31'b0, bus.done}, {31'b0, v.e_done});
        check("err_next_cycle", {31'b0, bus.err}, {31'b0, v.e_err});
        repeat (3) @(negedge clk);
        check("done", {31'b0, bus.done}, {31'b0, v.e_done});
        check("err", {31'b0, bus.err}, {31'b0, v.e_err});
        check("cpu_rst_n", {31'b0, bus.cpu_rst_n}, {31'b0, v.e_done});
        check("ready_after", {31'b0, bus.byte_ready}, 32'd0);
        check("write_count", 32'(wr_cnt - w0), 32'(v.e_wr));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vt [0:4];

    initial begin
        int w, w0;
        logic [7:0] b;

        vt[0] = '{frame: {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0},
                  nb: 11, e_done: 1'b1, e_err: 1'b0, e_wr: 2, gap: 0};
        vt[1] = '{frame: {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1},
                  nb: 11, e_done: 1'b0, e_err: 1'b1, e_wr: 2, gap: 0};
        vt[2] = '{frame: {8'h00, 8'h00, 8'h00, 64'h0},
                  nb: 3, e_done: 1'b1, e_err: 1'b0, e_wr: 0, gap: 0};
        vt[3] = '{frame: {8'h41, 8'h00, 72'h0},
                  nb: 2, e_done: 1'b0, e_err: 1'b1, e_wr: 0, gap: 0};
        vt[4] = '{frame: {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0},
                  nb: 11, e_done: 1'b1, e_err: 1'b0, e_wr: 2, gap: 50};

        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.reload     = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;

        #12;
        check("rst_byte_ready", {31'b0, bus.byte_ready}, 32'd1);
        check("rst_im_we", {31'b0, bus.im_we}, 32'd0);
        check("rst_im_waddr", 32'(bus.im_waddr), 32'd0);
        check("rst_im_wdata", bus.im_wdata, 32'd0);
        check("rst_cpu_rst_n", {31'b0, bus.cpu_rst_n}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        check("mem0", mem[0], 32'h0010_0513);
        check("mem1", mem[1], 32'h0020_0593);

        // Back-to-back frame: a byte held during the write cycle waits exactly one cycle
        run_vec(vt[0]);
        check("no_wait_first_payload", 32'(wlog[2]), 32'd0);
        check("wait_in_we_cycle", 32'(wlog[6]), 32'd1);

        // Full-capacity image: N == DEPTH
        pulse_reload();
        w0 = wr_cnt;
        max_addr = -1;
        send_byte(8'(DEPTH), 0, w);
        send_byte(8'(DEPTH >> 8), 0, w);
        for (int i = 0; i < DEPTH * 4; i++) begin
            b = 8'(i * 7 + 3);
            send_byte(b, 0, w);
        end
        send_byte(m_xor, 0, w);
        repeat (2) @(negedge clk);
        check("full_done", {31'b0, bus.done}, 32'd1);
        check("full_writes", 32'(wr_cnt - w0), 32'(DEPTH));
        check("full_max_addr", 32'(max_addr), 32'(DEPTH - 1));
        check("full_sb_empty", 32'(exp_q.size()), 32'd0);

        // reload with a byte offered mid-word drops it and the partial word
        pulse_reload();
        w0 = wr_cnt;
        send_byte(8'h01, 0, w);
        send_byte(8'h00, 0, w);
        send_byte(8'hAA, 0, w);
        send_byte(8'hBB, 0, w);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hCC;
        bus.reload     = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.reload     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reload_no_write", 32'(wr_cnt - w0), 32'd0);
        check("reload_back_ready", {31'b0, bus.byte_ready}, 32'd1);
        check("reload_back_done", {31'b0, bus.done}, 32'd0);
        send_byte(8'h01, 0, w);
        send_byte(8'h00, 0, w);
        send_byte(8'h11, 0, w);
        send_byte(8'h22, 0, w);
        send_byte(8'h33, 0, w);
        send_byte(8'h44, 0, w);
        send_byte(8'h44, 0, w);
        repeat (2) @(negedge clk);
        check("fresh_write_count", 32'(wr_cnt - w0), 32'd1);
        check("fresh_mem0", mem[0], 32'h4433_2211);
        check("fresh_done", {31'b0, bus.done}, 32'd1);
        check("fresh_cpu_rst_n", {31'b0, bus.cpu_rst_n}, 32'd1);

        // Asynchronous reset while running
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cpu_rst_n", {31'b0, bus.cpu_rst_n}, 32'd0);
        check("async_done", {31'b0, bus.done}, 32'd0);
        check("async_im_we", {31'b0, bus.im_we}, 32'd0);
        check("async_ready", {31'b0, bus.byte_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Asynchronous reset mid-word: partial word is never written
        w0 = wr_cnt;
        send_byte(8'h01, 0, w);
        send_byte(8'h00, 0, w);
        send_byte(8'h55, 0, w);
        send_byte(8'h66, 0, w);
        #2;
        rst_n = 1'b0;
        #1;
        check("midword_rst_ready", {31'b0, bus.byte_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check("midword_no_write", 32'(wr_cnt - w0), 32'd0);
        check("midword_im_we", {31'b0, bus.im_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
